dac_sweep_seq: RTL and testbench
================================

DAC_SWEEP_SEQ -- requirements
Module: dac_sweep_seq

Interface
REQ-001 SHALL have parameter CODE_W, default 8: width of each DAC code bus.
REQ-002 SHALL have parameter DWELL_W, default 8: width of the dwell input.
REQ-003 SHALL have a single clock and an active-low asynchronous reset; the ports are as listed below.
REQ-004 clk  in  1  sole clock; all state changes on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 start  in  1  request a sweep; sampled only in IDLE.
REQ-007 abort  in  1  synchronous cancel of a running sweep.
REQ-008 mode  in  2  sweep mode: 0 ramp-up, 1 ramp-down, 2 triangle, 3 hold.
REQ-009 chan_sel  in  2  channel select: 0 R, 1 G, 2 B, 3 all.
REQ-010 dwell  in  DWELL_W  clock cycles per code step; 0 is treated as 1.
REQ-011 hold_code  in  CODE_W  code driven in hold mode.
REQ-012 r, g, b  out  CODE_W each  true DAC codes (p-side switches).
REQ-013 rn, gn, bn  out  CODE_W each  complement codes (n-side switches).
REQ-014 busy  out  1  high while in RUN.
REQ-015 step_strobe  out  1  one-cycle pulse on each cycle the active code is loaded.
REQ-016 done  out  1  one-cycle pulse on normal sweep completion.

Function
REQ-017 SHALL implement the states IDLE, RUN and DONE; DONE SHALL last exactly one cycle and then return to IDLE.
REQ-018 SHALL, in IDLE with start=1 and abort=0, latch mode, chan_sel, the effective dwell and hold_code, and enter RUN on the same edge.
REQ-019 SHALL load the first code on the start edge (zero latency from the registered start), with busy=1 and step_strobe=1 in the following cycle.
REQ-020 SHALL hold each code for exactly max(dwell,1) cycles and then load the next code.
REQ-021 Ramp-up SHALL step codes 0,1,...,255 (256 steps).
REQ-022 Ramp-down SHALL step codes 255,...,0 (256 steps).
REQ-023 Triangle SHALL step codes 0..255..0 (511 steps; 255 occurs once).
REQ-024 Hold SHALL drive hold_code for 256 step periods, with step_strobe pulsing each period.
REQ-025 After the final step's dwell expires, the block SHALL enter DONE, assert done for 1 cycle with busy=0, and drive all codes to 0.
REQ-026 Selected channel(s) SHALL carry the sweep code; unselected channels SHALL carry code 0.
REQ-027 SHALL guarantee rn=~r, gn=~g and bn=~b at all times, registered in the same cycle so that no overlapping or break states occur.
REQ-028 SHALL ignore start while in RUN or DONE; latched configuration SHALL be immune to input changes during RUN.
REQ-029 abort in RUN SHALL return the block to IDLE on the next edge, with codes 0, no done pulse and no step_strobe.
REQ-030 If start and abort are both high in IDLE, abort SHALL win and the block SHALL stay in IDLE.
REQ-031 The code counter SHALL be CODE_W bits; direction reversal in triangle mode SHALL occur at 255 and SHALL NOT wrap.

Reset
REQ-032 SHALL, on rst_n low, immediately force IDLE, r/g/b=0, rn/gn/bn=all ones, busy=0, step_strobe=0, done=0, and clear the dwell and step counters.
REQ-033 Reset asserted mid-sweep SHALL behave as REQ-032; no done pulse SHALL be issued after release.

Structure
REQ-034 Package dac_seq_pkg SHALL hold the mode encoding enum, the state enum, the chan_sel constants and STEPS_RAMP=256, STEPS_TRI=511.
REQ-035 SHALL instantiate one sub-module, step_timer: a reloadable dwell down-counter that emits a tick on expiry.

Verification
REQ-036 Ramp-up, chan_sel=0, dwell=2, start pulse -> r steps 0..255 every 2 cycles, g=b=0, gn=bn=0xFF, done after 512 cycles of RUN.
REQ-037 Triangle, chan_sel=3, dwell=0 -> all channels step 0..255..0 every cycle, 511 step_strobes, one done pulse.
REQ-038 Hold, hold_code=0xA5, dwell=1 -> r=g=b=0xA5, rn=0x5A for 256 cycles, then codes return to 0.
REQ-039 Ramp-down, abort asserted at code 0x80 -> IDLE next edge, codes 0, no done; a start issued during RUN is ignored.
REQ-040 Start and abort together in IDLE -> no busy; rst_n pulsed mid-sweep -> outputs reset immediately and no done follows.
REQ-041 All scenarios SHALL check rn==~r, gn==~g and bn==~b every cycle.

Source files
------------

// File: rtl/dac_seq_pkg.sv
// Shared types and constants for the DAC sweep sequencer.
// Mode/state encodings, channel selects and sweep lengths.
package dac_seq_pkg;

  typedef enum logic [1:0] {
    MODE_UP   = 2'd0,
    MODE_DOWN = 2'd1,
    MODE_TRI  = 2'd2,
    MODE_HOLD = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [1:0] CH_R   = 2'd0;
  localparam logic [1:0] CH_G   = 2'd1;
  localparam logic [1:0] CH_B   = 2'd2;
  localparam logic [1:0] CH_ALL = 2'd3;

  localparam int STEP_W = 10;
  localparam logic [STEP_W-1:0] STEPS_RAMP = 10'd256;
  localparam logic [STEP_W-1:0] STEPS_TRI  = 10'd511;

  function automatic logic [STEP_W-1:0] last_step(mode_e m);
    return (m == MODE_TRI) ? STEPS_TRI - 10'd1
                           : STEPS_RAMP - 10'd1;
  endfunction

endpackage

// File: rtl/dac_sweep_seq_step_timer.sv
// Reloadable dwell down-counter; tick marks the last
// cycle of each dwell period.
module step_timer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               clr,
  input  logic [DWELL_W-1:0] period,
  output logic               tick
);

  logic [DWELL_W-1:0] cnt;
  logic [DWELL_W-1:0] per_q;
  logic               run;

  assign tick = run && (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      per_q <= '0;
      run   <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      run <= 1'b0;
    end else if (load) begin
      per_q <= period;
      cnt   <= period - DWELL_W'(1);
      run   <= 1'b1;
    end else if (tick) begin
      cnt <= per_q - DWELL_W'(1);
    end else if (run) begin
      cnt <= cnt - DWELL_W'(1);
    end
  end

endmodule

// File: rtl/dac_sweep_seq.sv
// DAC code sweep sequencer: ramp/triangle/hold sweeps
// onto R/G/B with complementary n-side codes.
module dac_sweep_seq
  import dac_seq_pkg::*;
#(
  parameter int CODE_W  = 8,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [1:0]         mode,
  input  logic [1:0]         chan_sel,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [CODE_W-1:0]  hold_code,
  output logic [CODE_W-1:0]  r,
  output logic [CODE_W-1:0]  g,
  output logic [CODE_W-1:0]  b,
  output logic [CODE_W-1:0]  rn,
  output logic [CODE_W-1:0]  gn,
  output logic [CODE_W-1:0]  bn,
  output logic               busy,
  output logic               step_strobe,
  output logic               done
);

  state_e              state, state_nxt;
  mode_e               mode_q;
  logic [1:0]          chan_q;
  logic [CODE_W-1:0]   hold_q;
  logic [CODE_W-1:0]   code_q, code_nxt;
  logic                dir_up_q, dir_nxt;
  logic [STEP_W-1:0]   step_q;
  logic [DWELL_W-1:0]  dwell_eff;
  logic [1:0]          chan_eff;
  logic [CODE_W-1:0]   first_code;
  logic [CODE_W-1:0]   r_nxt, g_nxt, b_nxt;
  logic                tick, last;
  logic                go, adv, fin, kill;

  localparam logic [CODE_W-1:0] CODE_MAX = '1;

  assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;
  assign last      = (step_q == last_step(mode_q));
  assign go        = (state == ST_IDLE) && start && !abort;
  assign kill      = (state == ST_RUN) && abort;
  assign adv       = (state == ST_RUN) && !abort && tick && !last;
  assign fin       = (state == ST_RUN) && !abort && tick && last;
  assign chan_eff  = go ? chan_sel : chan_q;

  step_timer #(.DWELL_W(DWELL_W)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (go),
    .clr    (kill | fin),
    .period (dwell_eff),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (go) state_nxt = ST_RUN;
      ST_RUN: begin
        if (abort)             state_nxt = ST_IDLE;
        else if (tick && last) state_nxt = ST_DONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ST_RUN);
    done = (state == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_UP;
      chan_q <= CH_R;
      hold_q <= '0;
    end else if (go) begin
      mode_q <= mode_e'(mode);
      chan_q <= chan_sel;
      hold_q <= hold_code;
    end
  end

  always_comb begin
    first_code = '0;
    unique case (mode_e'(mode))
      MODE_DOWN: first_code = CODE_MAX;
      MODE_HOLD: first_code = hold_code;
      default:   first_code = '0;
    endcase
  end

  // Triangle turns around at full scale instead of wrapping
  always_comb begin
    code_nxt = code_q;
    dir_nxt  = dir_up_q;
    if (go) begin
      code_nxt = first_code;
      dir_nxt  = 1'b1;
    end else if (adv) begin
      unique case (mode_q)
        MODE_UP:   code_nxt = code_q + CODE_W'(1);
        MODE_DOWN: code_nxt = code_q - CODE_W'(1);
        MODE_TRI: begin
          if (dir_up_q && code_q != CODE_MAX) begin
            code_nxt = code_q + CODE_W'(1);
          end else begin
            code_nxt = code_q - CODE_W'(1);
            dir_nxt  = 1'b0;
          end
        end
        default:   code_nxt = hold_q;
      endcase
    end
  end

  always_comb begin
    r_nxt = r;
    g_nxt = g;
    b_nxt = b;
    if (go || adv) begin
      r_nxt = (chan_eff == CH_R || chan_eff == CH_ALL) ? code_nxt : '0;
      g_nxt = (chan_eff == CH_G || chan_eff == CH_ALL) ? code_nxt : '0;
      b_nxt = (chan_eff == CH_B || chan_eff == CH_ALL) ? code_nxt : '0;
    end else if (kill || fin) begin
      r_nxt = '0;
      g_nxt = '0;
      b_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q      <= '0;
      dir_up_q    <= 1'b1;
      step_q      <= '0;
      step_strobe <= 1'b0;
      r           <= '0;
      g           <= '0;
      b           <= '0;
      rn          <= '1;
      gn          <= '1;
      bn          <= '1;
    end else begin
      code_q      <= code_nxt;
      dir_up_q    <= dir_nxt;
      step_strobe <= go | adv;
      if (go)       step_q <= '0;
      else if (adv) step_q <= step_q + STEP_W'(1);
      r  <= r_nxt;
      g  <= g_nxt;
      b  <= b_nxt;
      rn <= ~r_nxt;
      gn <= ~g_nxt;
      bn <= ~b_nxt;
    end
  end

endmodule

// File: tb/tb_dac_sweep_seq.sv
// Randomized bench for dac_sweep_seq against a step-index
// model of the sweep sequence.
module tb_dac_sweep_seq;

  localparam int CW = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [1:0]    chan_sel = 2'd0;
  logic [DW-1:0] dwell = 8'd1;
  logic [CW-1:0] hold_code = 8'd0;
  logic [CW-1:0] r, g, b, rn, gn, bn;
  logic          busy, step_strobe, done;

  int checks = 0;
  int failures = 0;

  dac_sweep_seq #(.CODE_W(CW), .DWELL_W(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .mode        (mode),
    .chan_sel    (chan_sel),
    .dwell       (dwell),
    .hold_code   (hold_code),
    .r           (r),
    .g           (g),
    .b           (b),
    .rn          (rn),
    .gn          (gn),
    .bn          (bn),
    .busy        (busy),
    .step_strobe (step_strobe),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // model: phase 0 idle, 1 run, 2 done; k = cycles since start edge
  int ph = 0, k = 0, md = 0, ch = 0, dd = 1, nn = 256, hc = 0;

  function automatic int sweep_code(int m, int s, int h);
    case (m)
      0:       return s;
      1:       return 255 - s;
      2:       return (s <= 255) ? s : 510 - s;
      default: return h;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph = 0;
    end else begin
      case (ph)
        0: if (start && !abort) begin
          md = int'(mode);
          ch = int'(chan_sel);
          dd = (dwell == 0) ? 1 : int'(dwell);
          hc = int'(hold_code);
          nn = (mode == 2'd2) ? 511 : 256;
          k  = 0;
          ph = 1;
        end
        1: if (abort) ph = 0;
           else begin
             k++;
             if (k == nn * dd) ph = 2;
           end
        default: ph = 0;
      endcase
    end
  end

  logic [7:0] er, eg, eb, ern, egn, ebn;
  logic       ebusy, estb, edone;
  int         cv;

  always @(negedge clk) begin
    er = 0; eg = 0; eb = 0;
    ebusy = 0; estb = 0; edone = 0;
    if (ph == 1) begin
      cv    = sweep_code(md, k / dd, hc);
      ebusy = 1;
      estb  = (k % dd == 0);
      if (ch == 0 || ch == 3) er = cv[7:0];
      if (ch == 1 || ch == 3) eg = cv[7:0];
      if (ch == 2 || ch == 3) eb = cv[7:0];
    end else if (ph == 2) begin
      edone = 1;
    end
    ern = ~er; egn = ~eg; ebn = ~eb;
    check("r", r, er);
    check("g", g, eg);
    check("b", b, eb);
    check("rn", rn, ern);
    check("gn", gn, egn);
    check("bn", bn, ebn);
    check("busy", busy, ebusy);
    check("step_strobe", step_strobe, estb);
    check("done", done, edone);
  end

  int n_busy = 0, n_strb = 0, n_done = 0;
  always @(negedge clk) begin
    if (busy)        n_busy++;
    if (step_strobe) n_strb++;
    if (done)        n_done++;
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start(int m, int c, int d, int h);
    @(negedge clk);
    mode      = m[1:0];
    chan_sel  = c[1:0];
    dwell     = d[7:0];
    hold_code = h[7:0];
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic run_full(string nm, int m, int c, int d, int h,
                          int exp_busy, int exp_strb);
    int b0, s0, d0;
    b0 = n_busy; s0 = n_strb; d0 = n_done;
    pulse_start(m, c, d, h);
    tick(exp_busy + 5);
    check({nm, "_busy_cycles"}, n_busy - b0, exp_busy);
    check({nm, "_strobes"}, n_strb - s0, exp_strb);
    check({nm, "_done_pulses"}, n_done - d0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, b0, bound, seen;
    tick(3);
    check("rst_r", r, 8'h00);
    check("rst_rn", rn, 8'hFF);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_strobe", step_strobe, 0);
    rst_n = 1'b1;
    tick(2);

    run_full("rampup", 0, 0, 2, 0, 512, 256);
    run_full("tri", 2, 3, 0, 0, 511, 511);

    b0 = n_busy; d0 = n_done;
    pulse_start(3, 3, 1, 8'hA5);
    tick(100);
    check("hold_r", r, 8'hA5);
    check("hold_g", g, 8'hA5);
    check("hold_rn", rn, 8'h5A);
    check("hold_bn", bn, 8'h5A);
    tick(200);
    check("hold_busy_cycles", n_busy - b0, 256);
    check("hold_done", n_done - d0, 1);
    check("hold_after_r", r, 8'h00);

    d0 = n_done;
    pulse_start(1, 1, 1, 0);
    tick(20);
    start = 1'b1; mode = 2'd0;
    tick(1);
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      if (g == 8'h80) seen = 1;
      else tick(1);
    end
    check("abort_reached_80", seen, 1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("abort_g", g, 8'h00);
    check("abort_gn", gn, 8'hFF);
    check("abort_busy", busy, 0);
    tick(10);
    check("abort_no_done", n_done - d0, 0);

    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", busy, 0);
    tick(2);
    check("start_abort_busy2", busy, 0);

    pulse_start(0, 3, 1, 0);
    tick(50);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_r", r, 8'h00);
    check("midrst_bn", bn, 8'hFF);
    check("midrst_busy", busy, 0);
    check("midrst_strobe", step_strobe, 0);
    @(negedge clk);
    rst_n = 1'b1;
    d0 = n_done;
    tick(600);
    check("midrst_no_done", n_done - d0, 0);

    for (int it = 0; it < 8; it++) begin
      pulse_start($urandom_range(3), $urandom_range(3),
                  $urandom_range(3), $urandom_range(255));
      bound = 0;
      while (ph != 0 && bound < 1600) begin
        start     = ($urandom_range(3) == 0);
        mode      = 2'($urandom_range(3));
        chan_sel  = 2'($urandom_range(3));
        dwell     = 8'($urandom_range(3));
        hold_code = 8'($urandom_range(255));
        abort     = ($urandom_range(700) == 0);
        tick(1);
        bound++;
      end
      start = 1'b0;
      abort = 1'b0;
      check("rand_terminated", (ph == 0), 1);
      tick(3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
